// File: rtl/buffered_handshake_if.sv
// buffered_handshake_if: valid/ready stream bundle seen from both sides of the buffer.
interface buffered_handshake_if #(parameter int DATA_WIDTH = 8);
   logic [DATA_WIDTH-1:0] idata;
   logic                  idata_vld;
   logic                  idata_rdy;
   logic [DATA_WIDTH-1:0] odata;
   logic                  odata_vld;
   logic                  odata_rdy;
   modport master (output idata, idata_vld, odata_rdy, input idata_rdy, odata, odata_vld);
   modport slave  (input idata, idata_vld, odata_rdy, output idata_rdy, odata, odata_vld);
endinterface

// File: rtl/buffered_handshake.sv
// buffered_handshake: two-entry skid buffer that fully registers data, valid and ready.
module buffered_handshake #(
   parameter int DATA_WIDTH = 8,
   parameter int RESET_TYPE = 1
) (
   input logic                clk,
   input logic                rst,
   buffered_handshake_if.slave bus
);
   if (RESET_TYPE != 1) begin : g_bad_reset_type
      $fatal(1, "buffered_handshake: only RESET_TYPE=1 (async active-high) is supported");
   end
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
   state_t                state;
   logic [DATA_WIDTH-1:0] main_data;
   logic [DATA_WIDTH-1:0] skid_data;
   logic                  main_vld;
   logic                  skid_vld;
   logic                  in_rdy;
   logic                  in_xfer;
   logic                  out_xfer;
   assign in_xfer       = bus.idata_vld && in_rdy;
   assign out_xfer      = main_vld && bus.odata_rdy;
   assign bus.odata     = main_data;
   assign bus.odata_vld = main_vld;
   assign bus.idata_rdy = in_rdy;
   // in_rdy resets low so the first edge after release only opens the input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         main_data <= '0;
         skid_data <= '0;
         main_vld  <= 1'b0;
         skid_vld  <= 1'b0;
         in_rdy    <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               in_rdy <= 1'b1;
               if (in_xfer) begin
                  main_data <= bus.idata;
                  main_vld  <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  main_data <= bus.idata;
               end else if (in_xfer) begin
                  skid_data <= bus.idata;
                  skid_vld  <= 1'b1;
                  in_rdy    <= 1'b0;
                  state     <= FULL;
               end else if (out_xfer) begin
                  main_vld <= 1'b0;
                  state    <= EMPTY;
               end
            end
            FULL: begin
               if (out_xfer) begin
                  main_data <= skid_data;
                  skid_vld  <= 1'b0;
                  in_rdy    <= 1'b1;
                  state     <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end
endmodule

// File: tb/tb_buffered_handshake.sv
// tb_buffered_handshake: directed and random-stall checks of the skid buffer.
module tb_buffered_handshake;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] q[$];
   logic [7:0] nxt;
   logic [7:0] exp_word;
   logic [7:0] prev_odata;
   logic       prev_stall;
   buffered_handshake_if #(.DATA_WIDTH(8)) bus ();
   buffered_handshake #(.DATA_WIDTH(8), .RESET_TYPE(1)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   initial begin
      bus.idata     = 8'hAA;
      bus.idata_vld = 1'b1;
      bus.odata_rdy = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("rst_vld", bus.odata_vld, 0);
      chk("rst_rdy", bus.idata_rdy, 0);
      chk("rst_data", bus.odata, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rel_rdy_low", bus.idata_rdy, 0);
      @(negedge clk);
      chk("rel_rdy_high", bus.idata_rdy, 1);
      chk("rel_no_xfer", bus.odata_vld, 0);
      // single word
      bus.idata = 8'h12;
      bus.odata_rdy = 1'b1;
      @(negedge clk);
      chk("single_data", bus.odata, 8'h12);
      chk("single_vld", bus.odata_vld, 1);
      bus.idata_vld = 1'b0;
      @(negedge clk);
      chk("single_drained", bus.odata_vld, 0);
      // streaming
      for (int i = 1; i <= 16; i++) begin
         bus.idata = 8'(i);
         bus.idata_vld = 1'b1;
         @(negedge clk);
         chk("stream_data", bus.odata, i);
         chk("stream_vld", bus.odata_vld, 1);
         chk("stream_rdy", bus.idata_rdy, 1);
      end
      bus.idata_vld = 1'b0;
      @(negedge clk);
      chk("stream_end", bus.odata_vld, 0);
      // backpressure
      bus.odata_rdy = 1'b0;
      bus.idata = 8'h21;
      bus.idata_vld = 1'b1;
      @(negedge clk);
      chk("bp_first", bus.odata, 8'h21);
      chk("bp_one_rdy", bus.idata_rdy, 1);
      bus.idata = 8'h22;
      @(negedge clk);
      chk("bp_full_rdy", bus.idata_rdy, 0);
      chk("bp_hold", bus.odata, 8'h21);
      bus.idata = 8'h23;
      @(negedge clk);
      chk("bp_reject_rdy", bus.idata_rdy, 0);
      chk("bp_reject_data", bus.odata, 8'h21);
      bus.odata_rdy = 1'b1;
      @(negedge clk);
      chk("bp_out2", bus.odata, 8'h22);
      chk("bp_rdy_back", bus.idata_rdy, 1);
      @(negedge clk);
      chk("bp_out3", bus.odata, 8'h23);
      bus.idata_vld = 1'b0;
      @(negedge clk);
      chk("bp_drained", bus.odata_vld, 0);
      // random stalls against a FIFO scoreboard
      nxt = 8'h50;
      prev_stall = 1'b0;
      prev_odata = '0;
      for (int c = 0; c < 1000; c++) begin
         if (prev_stall) chk("rand_stable", bus.odata, prev_odata);
         if (bus.odata_vld && bus.idata_vld == 1'b0 && bus.odata_rdy == 1'b0) begin end
         bus.idata = nxt;
         bus.idata_vld = 1'($urandom_range(0, 1));
         bus.odata_rdy = 1'($urandom_range(0, 1));
         if (bus.idata_vld && bus.idata_rdy) begin
            q.push_back(nxt);
            nxt = nxt + 8'd1;
         end
         if (bus.odata_vld && bus.odata_rdy) begin
            exp_word = (q.size() != 0) ? q.pop_front() : 8'hXX;
            chk("rand_order", bus.odata, exp_word);
         end
         prev_stall = bus.odata_vld && !bus.odata_rdy;
         prev_odata = bus.odata;
         @(negedge clk);
      end
      bus.idata_vld = 1'b0;
      bus.odata_rdy = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (bus.odata_vld) begin
            exp_word = (q.size() != 0) ? q.pop_front() : 8'hXX;
            chk("drain_order", bus.odata, exp_word);
         end
         @(negedge clk);
      end
      chk("drain_empty", q.size(), 0);
      chk("drain_vld", bus.odata_vld, 0);
      // mid-stream reset while FULL
      bus.odata_rdy = 1'b0;
      bus.idata_vld = 1'b1;
      bus.idata = 8'h31;
      @(negedge clk);
      bus.idata = 8'h32;
      @(negedge clk);
      chk("mid_full", bus.idata_rdy, 0);
      bus.idata_vld = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_vld", bus.odata_vld, 0);
      chk("mid_rst_rdy", bus.idata_rdy, 0);
      chk("mid_rst_data", bus.odata, 0);
      #1 rst = 1'b0;
      bus.odata_rdy = 1'b1;
      @(negedge clk);
      chk("mid_rel_rdy", bus.idata_rdy, 1);
      chk("mid_no_stale", bus.odata_vld, 0);
      bus.idata = 8'h40;
      bus.idata_vld = 1'b1;
      @(negedge clk);
      chk("mid_new_data", bus.odata, 8'h40);
      bus.idata_vld = 1'b0;
      @(negedge clk);
      chk("mid_no_skid", bus.odata_vld, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/buffered_handshake.md
# buffered_handshake

Two-entry skid buffer for a valid/ready stream. It fully registers the data, valid and ready paths, which breaks long combinational ready/valid chains between a producer and a consumer. It sustains one transfer per clock with no bubbles. It sits on any point-to-point streaming link, typically between pipeline stages of the packet-processing datapath.

## Interface
- DATA_WIDTH, default 8: width of idata/odata in bits.
- RESET_TYPE, default 1: reset style selector.
  - Only 1 is supported: asynchronous, active-high reset.
  - Any other value must fail elaboration.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- idata  input  DATA_WIDTH  upstream data.
- idata_vld  input  1  upstream data valid.
- idata_rdy  output  1  buffer can accept a word (registered).
- odata  output  DATA_WIDTH  downstream data (registered).
- odata_vld  output  1  odata holds a valid word (registered).
- odata_rdy  input  1  downstream accepts the word.

## Operation
- Transfer rules:
  - An input transfer occurs on a rising edge where idata_vld && idata_rdy.
  - An output transfer occurs on a rising edge where odata_vld && odata_rdy.
- Storage: main register (drives odata/odata_vld) plus one skid register with its own valid bit.
- States:
  - EMPTY: main empty, skid empty. idata_rdy=1, odata_vld=0.
  - ONE: main full, skid empty. idata_rdy=1, odata_vld=1.
  - FULL: main full, skid full. idata_rdy=0, odata_vld=1.
- Transitions:
  - EMPTY + input transfer -> ONE; idata loaded into main.
  - ONE + input only -> FULL; idata loaded into skid.
  - ONE + output only -> EMPTY.
  - ONE + input and output -> ONE; idata loaded into main.
  - ONE + neither -> ONE, hold.
  - FULL + output -> ONE; skid moves into main. No input is possible since idata_rdy=0.
  - FULL + no output -> FULL, hold.
- Order is strictly FIFO. No word is ever dropped or duplicated.
- odata must not change while odata_vld=1 and odata_rdy=0.
- idata is ignored whenever idata_rdy=0 or idata_vld=0.
- Data content is passed through unmodified; no arithmetic.

## Timing
- Reset (async assert, immediate): odata=0, odata_vld=0, idata_rdy=0, skid empty, state EMPTY.
- After rst deasserts, idata_rdy rises to 1 on the first rising edge. No transfer is accepted on that edge.
- Reset asserted mid-stream discards all buffered words, including main and skid. Outputs go to their reset values without waiting for a clock.
- Latency: a word accepted at edge N is on odata with odata_vld=1 immediately after edge N, i.e. one cycle.
- Throughput: with idata_vld=1 and odata_rdy=1 continuously, one word per cycle and the buffer stays in ONE.
- idata_rdy and odata_vld are flop outputs. Neither has a combinational path from odata_rdy or idata_vld.
- idata_rdy falls on the edge that enters FULL and rises on the edge that leaves FULL.

## Test plan
- Reset: assert rst with idata_vld=1, idata=0xAA -> odata_vld=0, idata_rdy=0, odata=0x00. idata_rdy=1 one edge after release.
- Single word: send 0x12 with odata_rdy=1 -> odata=0x12, odata_vld=1 the next cycle, then odata_vld=0 after it is consumed.
- Streaming: send 0x01..0x10 back-to-back with odata_rdy=1 -> same sequence out, one per cycle, one-cycle latency, idata_rdy always 1.
- Backpressure:
  - odata_rdy=0, send 0x21, 0x22 -> FULL: idata_rdy=0, odata=0x21 held; 0x23 is not accepted.
  - Raise odata_rdy -> outputs 0x21, 0x22, 0x23 in order.
- Random stall: random idata_vld/odata_rdy over 1000 cycles -> output sequence equals input sequence; odata stable while stalled.
- Mid-stream reset: in FULL, pulse rst asynchronously between edges -> odata_vld=0 immediately; no stale word appears after release.
